// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single-port sync RAM.
// After reset it clears the RAM to zero, then grants at most one access per cycle.
// Optional build macro RAM_ARB_PERF_EN adds conflict_cnt and a_wait_max counters.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ready,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_din,
`ifdef RAM_ARB_PERF_EN
    output logic [15:0]       conflict_cnt,
    output logic [7:0]        a_wait_max,
`endif
    input  logic [DATA_W-1:0] s_dout
);
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_rr, w_rr_nxt;
    logic              r_cen, r_wen, w_cen_nxt, w_wen_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_din, w_din_nxt;
    logic              w_a_gnt, w_b_gnt, w_rd_vld, w_rd_own;
    logic              r_p1_vld, r_p1_own, r_p2_vld, r_p2_own;

    // State, clear counter and round-robin pointer (rr=0 favours A, rr=1 favours B)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Next state, grants and the next RAM command
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_a_gnt     = 1'b0;
        w_b_gnt     = 1'b0;
        w_cen_nxt   = 1'b0;
        w_wen_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_rd_vld    = 1'b0;
        w_rd_own    = 1'b0;
        if (r_state == S_CLEAR) begin
            if (r_cnt == CNT_W'(DEPTH)) begin
                w_state_nxt = S_RUN;
            end else begin
                w_cen_nxt  = 1'b1;
                w_wen_nxt  = 1'b1;
                w_addr_nxt = ADDR_W'(r_cnt);
                w_din_nxt  = '0;
                w_cnt_nxt  = r_cnt + 1'b1;
            end
        end else begin
            w_a_gnt = a_req && (!b_req || !r_rr);
            w_b_gnt = b_req && !w_a_gnt;
            if (a_req && b_req) w_rr_nxt = w_a_gnt;
            if (w_a_gnt) begin
                w_cen_nxt  = 1'b1;
                w_wen_nxt  = a_we;
                w_addr_nxt = a_addr;
                w_din_nxt  = a_wdata;
                w_rd_vld   = !a_we;
                w_rd_own   = 1'b0;
            end else if (w_b_gnt) begin
                w_cen_nxt  = 1'b1;
                w_wen_nxt  = b_we;
                w_addr_nxt = b_addr;
                w_din_nxt  = b_wdata;
                w_rd_vld   = !b_we;
                w_rd_own   = 1'b1;
            end
        end
    end

    // Registered RAM interface
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cen  <= 1'b0;
            r_wen  <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_cen  <= w_cen_nxt;
            r_wen  <= w_wen_nxt;
            r_addr <= w_addr_nxt;
            r_din  <= w_din_nxt;
        end
    end

    // Two-stage read tag pipeline: stage 1 matches the RAM command, stage 2 the RAM output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_vld <= 1'b0;
            r_p1_own <= 1'b0;
            r_p2_vld <= 1'b0;
            r_p2_own <= 1'b0;
        end else begin
            r_p1_vld <= w_rd_vld;
            r_p1_own <= w_rd_own;
            r_p2_vld <= r_p1_vld;
            r_p2_own <= r_p1_own;
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign ready    = (r_state == S_RUN);
    assign cen      = r_cen;
    assign wen      = r_wen;
    assign s_addr   = r_addr;
    assign s_din    = r_din;
    assign a_rvalid = r_p2_vld && !r_p2_own;
    assign b_rvalid = r_p2_vld && r_p2_own;
    assign a_rdata  = a_rvalid ? s_dout : '0;
    assign b_rdata  = b_rvalid ? s_dout : '0;

`ifdef RAM_ARB_PERF_EN
    logic [15:0] r_conflict_cnt;
    logic [7:0]  r_a_wait, r_a_wait_max, w_a_wait_nxt;

    assign w_a_wait_nxt = (a_req && !w_a_gnt) ? ((r_a_wait == 8'hFF) ? r_a_wait : r_a_wait + 8'd1) : 8'd0;

    // Saturating conflict counter and longest A starvation run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= '0;
            r_a_wait       <= '0;
            r_a_wait_max   <= '0;
        end else begin
            if (r_state == S_RUN && a_req && b_req && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            r_a_wait <= w_a_wait_nxt;
            if (w_a_wait_nxt > r_a_wait_max) r_a_wait_max <= w_a_wait_nxt;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign a_wait_max   = r_a_wait_max;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural 256x64 RAM.
module tb_ram_arbiter;
    localparam logic [63:0] WDATA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] JUNK  = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [63:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [63:0] a_rdata, b_rdata;
    logic        ready, cen, wen;
    logic [7:0]  s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout = '0;
`ifdef RAM_ARB_PERF_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  a_wait_max;
`endif

    logic [63:0]  mem [256];
    logic [255:0] written = '0;
    int n_chk = 0;
    int n_err = 0;

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ready(ready), .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din),
`ifdef RAM_ARB_PERF_EN
        .conflict_cnt(conflict_cnt), .a_wait_max(a_wait_max),
`endif
        .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; never-written words read back as junk so the clear sweep is observable
    always @(posedge clk) begin
        if (cen) begin
            if (wen) begin
                mem[s_addr]     <= s_din;
                written[s_addr] <= 1'b1;
            end else begin
                s_dout <= written[s_addr] ? mem[s_addr] : JUNK;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk("sweep_ctl", {cen, wen, ready, a_gnt, b_gnt, s_addr}, {2'b11, 3'b000, 8'(k - 1)});
            chk("sweep_din", s_din, 64'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();
        chk("reset_ctl", {cen, wen, ready, a_rvalid, b_rvalid, s_addr}, 13'd0);
        chk("reset_din", s_din, 64'd0);

        // Sweep with A requesting throughout: no grants, nothing queued
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h33; a_wdata = 64'h1111;
        reset_n = 1'b1;
        sweep(256);
        a_req = 1'b0;
        tick();
        chk("ready_rise", {ready, cen, wen, s_addr}, {3'b100, 8'hFF});

        // A write then A read of the same address
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = WDATA;
        #1 chk("wr_gnt", {a_gnt, b_gnt}, 2'b10);
        tick();
        chk("wr_cmd", {cen, wen, s_addr}, {2'b11, 8'h10});
        chk("wr_din", s_din, WDATA);
        a_we = 1'b0;
        #1 chk("rd_gnt", {a_gnt, b_gnt}, 2'b10);
        tick();
        chk("rd_cmd", {cen, wen, s_addr, a_rvalid}, {2'b10, 8'h10, 1'b0});
        a_req = 1'b0;
        tick();
        chk("rd_valid", {a_rvalid, b_rvalid, cen}, 3'b100);
        chk("rd_adata", a_rdata, WDATA);
        chk("rd_bdata", b_rdata, 64'd0);
        tick();
        chk("rd_done", {a_rvalid, b_rvalid}, 2'b00);
        chk("rd_adata0", a_rdata, 64'd0);

        // Four conflicting reads: A,B,A,B; B reads the never-written 8'hFF
        a_addr = 8'h10; b_addr = 8'hFF; a_we = 1'b0; b_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rr_rvalid", {a_rvalid, b_rvalid},
                {(i >= 2) && (i % 2 == 0), (i >= 2) && (i % 2 == 1)});
            chk("rr_adata", a_rdata, ((i >= 2) && (i % 2 == 0)) ? WDATA : 64'd0);
            chk("rr_bdata", b_rdata, 64'd0);
            a_req = (i < 4); b_req = (i < 4);
            #1;
            if (i < 4) chk("rr_gnt", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;

        // B alone leaves rr on A; the next conflict goes to A, then B
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 64'h5555;
        #1 chk("b_only_gnt", {a_gnt, b_gnt}, 2'b01);
        tick();
        chk("b_wr_cmd", {cen, wen, s_addr}, {2'b11, 8'h20});
        a_req = 1'b1; b_we = 1'b0;
        #1 chk("rr_hold_gnt", {a_gnt, b_gnt}, 2'b10);
        tick();
        #1 chk("rr_next_gnt", {a_gnt, b_gnt}, 2'b01);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        #1 chk("idle_gnt", {a_gnt, b_gnt}, 2'b00);
        tick();
        chk("idle_cmd", {cen, wen, s_addr}, {2'b00, 8'h20});

`ifdef RAM_ARB_PERF_EN
        chk("perf_cnt6", 64'(conflict_cnt), 64'd6);
        a_req = 1'b1; b_req = 1'b1;
        repeat (5) tick();
        a_req = 1'b0; b_req = 1'b0;
        chk("perf_cnt11", 64'(conflict_cnt), 64'd11);
        chk("perf_wait", 64'(a_wait_max >= 8'd1), 64'd1);
        repeat (2) tick();
`endif

        // Reset while a read is in flight drops its rvalid
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        #1 chk("flight_gnt", {a_gnt, b_gnt}, 2'b10);
        tick();
        a_req = 1'b0;
        reset_n = 1'b0;
        #1 chk("async_rst", {ready, cen, wen, a_rvalid, s_addr}, 12'd0);
        tick();
        chk("flight_drop", {a_rvalid, b_rvalid}, 2'b00);
        reset_n = 1'b1;

        // Reset pulse mid-sweep restarts the sweep from 0
        sweep(100);
        reset_n = 1'b0;
        #1 chk("sweep_rst", {ready, cen, wen, s_addr}, 11'd0);
        tick();
        reset_n = 1'b1;
        sweep(256);
        tick();
        chk("ready_again", {ready, cen, wen}, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 256x64 single-port synchronous RAM (cen/wen/s_addr/s_din/s_dout).
- After reset, sweeps the RAM to zero, then grants one access per cycle to requester A or B.
- Returns read data to the requester that issued the read.
- Sits between the two datapath masters and the RAM instance.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 64, RAM data width
- DEPTH, 256, number of words cleared by the post-reset sweep (must be at most 2^ADDR_W)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A access request; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A request accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_W  A read data; 0 when a_rvalid=0
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- ready  out  1  clear sweep finished; arbiter accepting
- cen  out  1  RAM chip enable (registered)
- wen  out  1  RAM write enable (registered)
- s_addr  out  ADDR_W  RAM address (registered)
- s_din  out  DATA_W  RAM write data (registered)
- s_dout  in  DATA_W  RAM read data, valid one cycle after the RAM samples cen=1, wen=0

Behaviour:
- Reset (reset_n=0, async):
  - state=CLEAR, clear counter=0, rr pointer=A.
  - cen=wen=0, s_addr=0, s_din=0, ready=0, a_rvalid=b_rvalid=0.
  - Read pipeline tags cleared.
- State CLEAR:
  - Each cycle registers cen=1, wen=1, s_addr=counter, s_din=0; counter increments.
  - After the write of address DEPTH-1 is issued, go to RUN on the next edge; ready=1 from that edge.
  - a_gnt=b_gnt=0 throughout; requests are ignored, not queued.
- State RUN, cycle n:
  - Only A requesting: A wins. Only B requesting: B wins.
  - Both requesting: the requester indicated by rr wins; rr then points at the loser.
  - rr is unchanged when there is no conflict.
  - Winner's gnt=1 combinationally in cycle n.
  - At edge n+1: cen=1, wen=winner's we, s_addr/s_din=winner's addr/wdata.
  - If no request: cen=0, wen=0; s_addr and s_din hold.
- Read pipeline:
  - Owner ID and read flag are delayed two stages.
  - A read granted in cycle n gives x_rvalid=1 for exactly cycle n+2, with x_rdata=s_dout.
  - The other requester's rdata stays 0.
- Write latency:
  - A write granted in cycle n is in RAM after edge n+2.
  - A read of the same address granted in cycle n+1 returns the new data.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when the other port is idle.
- Reset asserted mid-sweep or mid-read:
  - In-flight rvalid is dropped.
  - The sweep restarts from address 0.

Optional Feature:
- Macro: RAM_ARB_PERF_EN
- Defined:
  - Adds output conflict_cnt (16 bits): increments when a_req and b_req are both 1 in RUN; saturates at 16'hFFFF.
  - Adds output a_wait_max (8 bits): longest run of consecutive cycles with a_req=1 and a_gnt=0, saturating at 8'hFF.
  - Both reset to 0.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset, then idle: ready rises exactly 256 cycles after the first post-reset edge. cen=wen=1 for those 256 cycles with s_addr 0..255 and s_din=0, then cen=0.
- After ready, A writes addr 8'h10 data 64'hDEAD_BEEF_0123_4567, then A reads 8'h10 the next cycle: a_gnt both cycles; a_rvalid=1 two cycles after the read grant with a_rdata=64'hDEAD_BEEF_0123_4567; b_rvalid=0.
- a_req=b_req=1 for 4 cycles, all reads: grants alternate A,B,A,B starting with A. rvalid alternates with the same order, 2 cycles delayed.
- B read of a never-written addr 8'hFF: b_rdata=0 (proves clear sweep).
- Pulse reset_n low mid-sweep at counter=100: outputs zero immediately. After release the sweep restarts at 0 and ready takes 256 further cycles.
- RAM_ARB_PERF_EN build: 5 cycles of simultaneous requests give conflict_cnt=5. a_wait_max≥1.
